// File: rtl/sram_like_arbiter.sv
// Shares one sram-like slave port between the instruction-fetch and data masters, one access outstanding.
// Optional macro ARB_STARVE_GUARD_EN adds a counter that lets the lower-priority master win after STARVE_MAX losses.
module sram_like_arbiter #(
    parameter int DATA_FIRST = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        i_busy,
    output logic        d_busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ADDR = 3'd1,
        I_DATA = 3'd2,
        D_ADDR = 3'd3,
        D_DATA = 3'd4
    } state_t;

    state_t state_q, state_d;
    state_t arb_next;
    logic   any_req;
    logic   hi_req;
    logic   lo_req;
    logic   lo_wins;
    logic   win_data;
    logic   arb_en;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_max_check
        $error("sram_like_arbiter: STARVE_MAX must be in 1..15");
    end

    assign any_req = i_req | d_req;
    assign hi_req  = (DATA_FIRST != 0) ? d_req : i_req;
    assign lo_req  = (DATA_FIRST != 0) ? i_req : d_req;

    // A new owner is chosen from IDLE, or in the very cycle the current access completes.
    assign arb_en = (state_q == IDLE)
                  | (((state_q == I_DATA) | (state_q == D_DATA)) & mem_data_ok);

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;

    assign lo_wins = lo_req & (~hi_req | (starve_q >= STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (arb_en) begin
            if (lo_wins) begin
                starve_d = 4'd0;
            end else if (lo_req && (starve_q != 4'hF)) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign lo_wins = lo_req & ~hi_req;
`endif

    assign win_data = (DATA_FIRST != 0) ? ~lo_wins : lo_wins;

    always_comb begin
        arb_next = IDLE;
        if (any_req) begin
            if (win_data) begin
                arb_next = D_ADDR;
            end else begin
                arb_next = I_ADDR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping the request before acceptance abandons the grant without touching the slave.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, I_DATA, D_DATA: begin
                if (arb_en) begin
                    state_d = arb_next;
                end
            end
            I_ADDR: begin
                if (!i_req) begin
                    state_d = IDLE;
                end else if (mem_addr_ok) begin
                    state_d = I_DATA;
                end
            end
            D_ADDR: begin
                if (!d_req) begin
                    state_d = IDLE;
                end else if (mem_addr_ok) begin
                    state_d = D_DATA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        i_addr_ok = 1'b0;
        i_data_ok = 1'b0;
        i_rdata   = 32'd0;
        d_addr_ok = 1'b0;
        d_data_ok = 1'b0;
        d_rdata   = 32'd0;
        case (state_q)
            I_ADDR: begin
                mem_req   = i_req;
                mem_size  = 2'd2;
                mem_addr  = i_addr;
                i_addr_ok = mem_addr_ok & i_req;
            end
            D_ADDR: begin
                mem_req   = d_req;
                mem_wr    = d_wr;
                mem_size  = d_size;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_addr_ok = mem_addr_ok & d_req;
            end
            I_DATA: begin
                i_data_ok = mem_data_ok;
                i_rdata   = mem_data_ok ? mem_rdata : 32'd0;
            end
            D_DATA: begin
                d_data_ok = mem_data_ok;
                d_rdata   = mem_data_ok ? mem_rdata : 32'd0;
            end
            default: begin
            end
        endcase
    end

    assign i_busy = (i_req & ~i_addr_ok) | ((state_q == I_DATA) & ~mem_data_ok);
    assign d_busy = (d_req & ~d_addr_ok) | ((state_q == D_DATA) & ~mem_data_ok);

endmodule
